// File: rtl/oit_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oit_bcd_pkg
// Description : Shared types and constants for the binary-to-BCD converter.
//               Holds the converter state encoding, the saturated BCD digit
//               value used on overflow, and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package oit_bcd_pkg;

    // Converter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_t;

    // Every nibble of a saturated (overflowed) result
    localparam logic [3:0] c_BCD_NINE = 4'h9;

    // Bits needed to hold any value in 0..n-1 (never less than one bit)
    function automatic int oitBits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oit_bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : oit_bcd_digit_adj
// Description : Combinational double-dabble digit cell. Adds 3 to a BCD digit
//               whose value is 5..9 so that the following left shift carries
//               correctly into the next decade.
// Ports       : i_digit - current BCD digit
//               o_digit - adjusted digit (at most 4'hC)
// Revision    : 1.0 - initial release
// ============================================================================
module oit_bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/oit_bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : oit_bin_to_bcd
// Description : Sequential binary-to-BCD converter (shift-and-add-3), one
//               input bit per clock. Result register only updates at the end
//               of a conversion so downstream displays never see partial data.
// Ports       : clock    - system clock, rising edge
//               reset    - asynchronous active-low reset
//               start    - conversion request, sampled only when idle
//               in       - unsigned binary value, captured on accepted start
//               busy     - conversion in progress
//               done     - one-cycle pulse when out/overflow update
//               overflow - last value did not fit in DIGITS decimal digits
//               out      - packed BCD, digit 0 (ones) in bits [3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module oit_bin_to_bcd
    import oit_bcd_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [DIGITS*4-1:0]   out
);

    localparam int c_CNT_W = oitBits(WIDTH + 1);
    localparam int c_ACC_W = DIGITS * 4;

    bcd_state_t           r_state;
    bcd_state_t           w_state_next;
    logic [WIDTH-1:0]     r_sr;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_ACC_W-1:0]   w_acc_adj;
    logic                 r_ovf;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overflow;
    logic [c_ACC_W-1:0]   r_out;

    // One add-3 cell per decade, applied before every shift
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            oit_bcd_digit_adj u_adj (
                .i_digit (r_acc[4*g +: 4]),
                .o_digit (w_acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == c_CNT_W'(1)) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sr       <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_out      <= '0;
        end else begin
            // busy tracks the state being entered so it is already high in
            // the cycle after the accepting edge and low in the done cycle
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sr  <= in;
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        r_cnt <= c_CNT_W'(WIDTH);
                    end
                end
                ST_SHIFT: begin
                    // {ovf_bit, acc, sr} <<= 1 after the add-3 adjust; the bit
                    // leaving the top digit makes the overflow sticky
                    r_acc <= {w_acc_adj[c_ACC_W-2:0], r_sr[WIDTH-1]};
                    r_sr  <= r_sr << 1;
                    r_ovf <= r_ovf | w_acc_adj[c_ACC_W-1];
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                ST_DONE: begin
                    r_out      <= r_ovf ? {DIGITS{c_BCD_NINE}} : r_acc;
                    r_overflow <= r_ovf;
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign out      = r_out;

endmodule
`default_nettype wire
